image_writer: RTL and testbench
===============================

Name: image_writer

Overview:
- Write-back path for the disk image held in SRAM; the counterpart of the image read path.
- When the SD host requests a sector write (sd_wr[0]), the block acknowledges and streams 512 bytes from the host sector buffer (sd_buff_addr / sd_buff_din) into SRAM at the sector's image location, using the same LBA-to-SRAM mapping as the read path.
- It sits between the SD host interface and the SRAM arbiter port reserved for image writes.

Parameters:
- LBA_OFFSET, 256: LBAs strictly greater than this value have it subtracted before mapping.
- BUF_LATENCY, 1: cycles from a sd_buff_addr change to valid sd_buff_din. Legal range 1..3.
- SRAM_AW, 19: SRAM address width. Sector index width is SRAM_AW-9 (10 bits).

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous reset, active-high
- sd_lba  in  32  sector LBA requested by the host
- sd_rd  in  2  read requests; ignored by this block
- sd_wr  in  2  write requests; only bit 0 is used
- sd_ack  out  1  transfer in progress
- sd_buff_addr  out  9  byte index into the host sector buffer
- sd_buff_din  in  8  sector buffer data, valid BUF_LATENCY cycles after the address
- sram_addr_o  out  SRAM_AW  SRAM byte address
- sram_data_o  out  8  SRAM write data
- sram_we_o  out  1  SRAM write strobe, active-high, one cycle per byte
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle pulse at the end of a sector
- err_o  out  1  sticky out-of-range flag

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index 0; wait counter 0.
- Reset mid-transfer: at the next edge, state is IDLE, sd_ack=0 and sram_we_o=0. SRAM keeps the bytes already written. No done_o pulse.
- LBA mapping, computed in IDLE on accept:
  - m = (sd_lba[16:0] > LBA_OFFSET) ? sd_lba[16:0] - LBA_OFFSET : sd_lba[16:0], computed 17-bit unsigned.
  - LBA 256 is not offset and maps to 256.
  - sector = m[9:0]. Overflow when m[16:10] != 0.
  - Latch sector and the overflow flag for the whole transfer.
- States and transitions:
  - IDLE: if sd_wr[0]=1, then sd_ack<=1, idx<=0, err_o<=overflow, go to ADDR. Otherwise stay.
  - ADDR: sd_buff_addr<=idx; load wait counter with BUF_LATENCY; go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, go to LATCH.
  - LATCH: sram_data_o<=sd_buff_din; sram_addr_o<={sector, idx}; go to WE.
  - WE: sram_we_o=1 for exactly this cycle, unless the transfer is in overflow; go to HOLD.
  - HOLD: sram_we_o=0; address and data held stable; if idx==511 go to DONE, else idx<=idx+1 and go to ADDR.
  - DONE: sd_ack<=0; done_o=1 for one cycle; go to IDLE.
- Overflow transfer: the full handshake still runs (512 iterations, ack, done_o) with no SRAM strobe. err_o stays set until the next accepted request clears or re-sets it.
- Timing per byte: 4+BUF_LATENCY cycles (5 at the default).
- Sector latency with BUF_LATENCY=1: sd_ack rises 1 cycle after sd_wr[0] is sampled high in IDLE; done_o fires 2561 cycles after acceptance.
- Handshake rules:
  - The host deasserts sd_wr[0] after seeing sd_ack rise.
  - sd_wr[0] is sampled only in IDLE. If it is still high on return to IDLE, a new transfer starts (level-triggered).
  - sd_lba changes during a transfer are ignored.
- sd_buff_addr and sram_addr_o hold their last values while idle.
- Byte-index wrap: idx never exceeds 511; no wrap into the next sector.
- Simultaneous sd_rd and sd_wr: this block acts on sd_wr[0] only; arbitration belongs to the top level.

Test Plan:
1. sd_lba=5, sd_wr[0] pulse, buffer byte i = i[7:0] → 512 sram_we_o pulses at addresses 0x00A00..0x00BFF with data 0x00..0xFF repeating; sd_ack high 2561 cycles; one done_o pulse; err_o=0.
2. sd_lba=300 → sector 44; first write at 0x05800, last at 0x059FF.
3. sd_lba=256, then sd_lba=257 → sectors 256 (base 0x20000) and 1 (base 0x00200), confirming the strict greater-than comparison.
4. sd_lba=2000 → m=1744, overflow: err_o=1, zero sram_we_o pulses, sd_ack and done_o still complete. Next request with sd_lba=7 clears err_o.
5. reset_i asserted while idx=100 → next edge sd_ack=0, sram_we_o=0, busy_o=0; exactly 100 strobes issued; no done_o pulse.
6. BUF_LATENCY=3, sd_wr[0] held high for 4 cycles → correct data captured with 7 cycles per byte; a second transfer starts only if sd_wr[0] is high in IDLE after DONE.

Source files
------------

// File: rtl/image_writer.sv
// Disk-image write-back path: copies one 512-byte host sector buffer into SRAM
// at the image location derived from the sector LBA.
module image_writer #(
  parameter int unsigned LBA_OFFSET  = 256,
  parameter int unsigned BUF_LATENCY = 1,
  parameter int unsigned SRAM_AW     = 19
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [31:0]        sd_lba,
  input  logic [1:0]         sd_rd,
  input  logic [1:0]         sd_wr,
  output logic               sd_ack,
  output logic [8:0]         sd_buff_addr,
  input  logic [7:0]         sd_buff_din,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [7:0]         sram_data_o,
  output logic               sram_we_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned SW = SRAM_AW - 9;
  localparam logic [1:0] WAIT_LOAD = 2'(BUF_LATENCY);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_WE    = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [8:0]         idx_q, idx_d;
  logic [1:0]         wait_q, wait_d;
  logic [SW-1:0]      sector_q, sector_d;
  logic               ovf_q, ovf_d;
  logic               ack_q, ack_d;
  logic [8:0]         baddr_q, baddr_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [7:0]         sdata_q, sdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [16:0]        lba_lo, lba_map;
  logic [SW-1:0]      map_sector;
  logic               map_ovf;

  // Read requests, the upper write bit and the high LBA bits play no part here.
  logic unused_inputs;
  assign unused_inputs = ^{sd_rd, sd_wr[1], sd_lba[31:17]};

  // Strict greater-than: LBA_OFFSET itself maps unchanged.
  always_comb begin
    lba_lo     = sd_lba[16:0];
    lba_map    = (lba_lo > 17'(LBA_OFFSET)) ? (lba_lo - 17'(LBA_OFFSET)) : lba_lo;
    map_sector = lba_map[SW-1:0];
    map_ovf    = (lba_map >> SW) != '0;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    sector_d = sector_q;
    ovf_d    = ovf_q;
    ack_d    = ack_q;
    baddr_d  = baddr_q;
    saddr_d  = saddr_q;
    sdata_d  = sdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (sd_wr[0]) begin
          ack_d    = 1'b1;
          idx_d    = '0;
          sector_d = map_sector;
          ovf_d    = map_ovf;
          err_d    = map_ovf;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        baddr_d = idx_q;
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 2'd1;
        if (wait_q <= 2'd1) begin
          wait_d  = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        sdata_d = sd_buff_din;
        saddr_d = {sector_q, idx_q};
        state_d = S_WE;
      end
      S_WE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (idx_q == 9'd511) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        ack_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      sector_q <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      baddr_q  <= '0;
      saddr_q  <= '0;
      sdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      sector_q <= sector_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      baddr_q  <= baddr_d;
      saddr_q  <= saddr_d;
      sdata_q  <= sdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Strobe is decoded from state so a reset drops it on the very next edge.
  assign sram_we_o    = (state_q == S_WE) && !ovf_q;
  assign busy_o       = (state_q != S_IDLE);
  assign sd_ack       = ack_q;
  assign sd_buff_addr = baddr_q;
  assign sram_addr_o  = saddr_q;
  assign sram_data_o  = sdata_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_image_writer.sv
// Directed bench for image_writer: one instance at BUF_LATENCY=1, one at 3,
// each fed by a sector-buffer model whose byte i reads as i[7:0] ^ key.
module tb_image_writer;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          nvec = 0;
  int          nmis = 0;

  logic [31:0] lba1, lba3;
  logic [1:0]  rd1, wr1, rd3, wr3;
  logic        ack1, we1, busy1, done1, err1;
  logic        ack3, we3, busy3, done3, err3;
  logic [8:0]  ba1, ba3;
  logic [7:0]  din1, din3, sd1, sd3, p0, p1;
  logic [18:0] sa1, sa3;

  always #5 clk = ~clk;

  image_writer #(.LBA_OFFSET(256), .BUF_LATENCY(1), .SRAM_AW(19)) dut1 (
    .clk_i(clk), .reset_i(rst), .sd_lba(lba1), .sd_rd(rd1), .sd_wr(wr1),
    .sd_ack(ack1), .sd_buff_addr(ba1), .sd_buff_din(din1),
    .sram_addr_o(sa1), .sram_data_o(sd1), .sram_we_o(we1),
    .busy_o(busy1), .done_o(done1), .err_o(err1));

  image_writer #(.LBA_OFFSET(256), .BUF_LATENCY(3), .SRAM_AW(19)) dut3 (
    .clk_i(clk), .reset_i(rst), .sd_lba(lba3), .sd_rd(rd3), .sd_wr(wr3),
    .sd_ack(ack3), .sd_buff_addr(ba3), .sd_buff_din(din3),
    .sram_addr_o(sa3), .sram_data_o(sd3), .sram_we_o(we3),
    .busy_o(busy3), .done_o(done3), .err_o(err3));

  // Monitor state per instance; base/key describe the expected image of the current sector.
  int          we_cnt1, bad1, ack_cyc1, done_cnt1, done_cyc1, acc1;
  logic [18:0] first1, last1, base1;
  logic [7:0]  key1;
  int          we_cnt3, bad3, done_cnt3, done_cyc3, acc3, prev3, gmin3, gmax3;
  logic [18:0] base3;
  logic [7:0]  key3;

  always @(posedge clk) din1 <= ba1[7:0] ^ key1;
  always @(posedge clk) begin
    p0   <= ba3[7:0] ^ key3;
    p1   <= p0;
    din3 <= p1;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (we1) begin
      if (we_cnt1 == 0) first1 = sa1;
      last1 = sa1;
      if (sa1 !== base1 + 19'(we_cnt1) || sd1 !== (8'(we_cnt1) ^ key1)) bad1++;
      we_cnt1++;
    end
    if (ack1) ack_cyc1++;
    if (done1) begin
      done_cnt1++;
      done_cyc1 = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (we3) begin
      if (we_cnt3 != 0) begin
        if (cyc - prev3 < gmin3) gmin3 = cyc - prev3;
        if (cyc - prev3 > gmax3) gmax3 = cyc - prev3;
      end
      prev3 = cyc;
      if (sa3 !== base3 + 19'(we_cnt3) || sd3 !== (8'(we_cnt3) ^ key3)) bad3++;
      we_cnt3++;
    end
    if (done3) begin
      done_cnt3++;
      done_cyc3 = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr1(input logic [18:0] base, input logic [7:0] key);
    we_cnt1 = 0; bad1 = 0; ack_cyc1 = 0; done_cnt1 = 0; done_cyc1 = 0;
    first1 = '0; last1 = '0; base1 = base; key1 = key;
  endtask

  task automatic clr3(input logic [18:0] base, input logic [7:0] key);
    we_cnt3 = 0; bad3 = 0; done_cnt3 = 0; done_cyc3 = 0; prev3 = 0;
    gmin3 = 9999; gmax3 = 0; base3 = base; key3 = key;
  endtask

  task automatic start1(input logic [31:0] lba);
    lba1 = lba;
    wr1  = 2'b01;
    @(negedge clk);
    acc1 = cyc;
    wr1  = 2'b00;
    chk("ack1_rise", {31'd0, ack1}, 32'd1);
  endtask

  task automatic wait_done1();
    int n = 0;
    while (done_cnt1 == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done1_seen", done_cnt1, 32'd1);
  endtask

  task automatic wait_done3();
    int n = 0;
    while (done_cnt3 == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done3_seen", done_cnt3, 32'd1);
  endtask

  task automatic sector1(input string tag, input logic [18:0] first, input logic [18:0] last);
    chk({tag, "_count"}, we_cnt1, 32'd512);
    chk({tag, "_bytes"}, bad1, 32'd0);
    chk({tag, "_first"}, {13'd0, first1}, {13'd0, first});
    chk({tag, "_last"}, {13'd0, last1}, {13'd0, last});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lba1 = '0; rd1 = '0; wr1 = '0; lba3 = '0; rd3 = '0; wr3 = '0;
    clr1('0, '0);
    clr3('0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ctl1", {27'd0, ack1, we1, busy1, done1, err1}, 32'd0);
    chk("rst_addr1", {4'd0, sa1, ba1}, 32'd0);
    chk("rst_ctl3", {27'd0, ack3, we3, busy3, done3, err3}, 32'd0);
    rst = 1'b0;

    rd1 = 2'b11;
    repeat (3) @(negedge clk);
    chk("rd_ignored", {31'd0, busy1}, 32'd0);
    rd1 = 2'b00;

    // LBA 5: sector 5 at 0x00A00, byte i holds i
    clr1(19'h00A00, 8'h00);
    start1(32'd5);
    chk("t1_busy", {31'd0, busy1}, 32'd1);
    wait_done1();
    chk("t1_done_lat", done_cyc1 - acc1, 32'd2561);
    repeat (2) @(negedge clk);
    sector1("t1", 19'h00A00, 19'h00BFF);
    chk("t1_ack_cycles", ack_cyc1, 32'd2561);
    chk("t1_done_pulses", done_cnt1, 32'd1);
    chk("t1_idle", {29'd0, ack1, busy1, err1}, 32'd0);

    // LBA 300 -> 44; mid-transfer LBA change must not matter
    clr1(19'h05800, 8'h5A);
    start1(32'd300);
    lba1 = 32'd999;
    wait_done1();
    repeat (2) @(negedge clk);
    sector1("t2", 19'h05800, 19'h059FF);

    clr1(19'h20000, 8'hC3);
    start1(32'd256);
    wait_done1();
    repeat (2) @(negedge clk);
    sector1("t3a", 19'h20000, 19'h201FF);

    clr1(19'h00200, 8'h11);
    start1(32'd257);
    wait_done1();
    repeat (2) @(negedge clk);
    sector1("t3b", 19'h00200, 19'h003FF);

    // LBA 2000 -> 1744, out of range: full handshake, no strobes
    clr1(19'h00000, 8'h00);
    start1(32'd2000);
    chk("t4_err_set", {31'd0, err1}, 32'd1);
    wait_done1();
    repeat (2) @(negedge clk);
    chk("t4_no_strobes", we_cnt1, 32'd0);
    chk("t4_ack_cycles", ack_cyc1, 32'd2561);
    chk("t4_err_sticky", {31'd0, err1}, 32'd1);

    clr1(19'h00E00, 8'h77);
    start1(32'd7);
    chk("t4_err_clear", {31'd0, err1}, 32'd0);
    wait_done1();
    repeat (2) @(negedge clk);
    sector1("t4b", 19'h00E00, 19'h00FFF);

    // Reset with idx at 100
    clr1(19'h0A000, 8'hE1);
    start1(32'd80);
    for (int n = 0; n < 1000 && we_cnt1 < 100; n++) @(negedge clk);
    chk("t5_reach100", we_cnt1, 32'd100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ctl", {29'd0, ack1, we1, busy1}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_strobes", we_cnt1, 32'd100);
    chk("t5_bytes", bad1, 32'd0);
    chk("t5_no_done", done_cnt1, 32'd0);
    chk("t5_idle", {31'd0, busy1}, 32'd0);

    // BUF_LATENCY=3, request held 4 cycles: 7 cycles per byte, no restart
    clr3(19'h01200, 8'h3C);
    lba3 = 32'd9;
    wr3  = 2'b01;
    @(negedge clk);
    acc3 = cyc;
    chk("t6_ack", {31'd0, ack3}, 32'd1);
    repeat (3) @(negedge clk);
    wr3 = 2'b00;
    wait_done3();
    chk("t6_done_lat", done_cyc3 - acc3, 32'd3585);
    repeat (3) @(negedge clk);
    chk("t6_no_restart", {31'd0, busy3}, 32'd0);
    chk("t6_count", we_cnt3, 32'd512);
    chk("t6_bytes", bad3, 32'd0);
    chk("t6_gap_min", gmin3, 32'd7);
    chk("t6_gap_max", gmax3, 32'd7);

    // Request still high when the sector ends: a new transfer begins
    clr3(19'h01800, 8'h00);
    lba3 = 32'd12;
    wr3  = 2'b01;
    @(negedge clk);
    wait_done3();
    @(negedge clk);
    chk("t6_restart", {30'd0, busy3, ack3}, 32'd3);
    chk("t6b_count", we_cnt3, 32'd512);
    chk("t6b_bytes", bad3, 32'd0);
    wr3 = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
